// File: rtl/cpu_run_monitor.sv
`timescale 1ns/1ps
// Run controller for a CPU core under test: sequences core reset, detects the
// halt fetch or a cycle timeout, and captures stores into a signature window.
module cpu_run_monitor #(
    parameter int                ADDR_W        = 10,
    parameter int                DATA_W        = 32,
    parameter logic [DATA_W-1:0] HALT_WORD     = 32'h0000_0000,
    parameter int                RESET_CYCLES  = 1,
    parameter int                SETTLE_CYCLES = 1,
    parameter int                DRAIN_CYCLES  = 4,
    parameter int                TIMEOUT       = 4096,
    parameter int                CNT_W         = 16,
    parameter logic [ADDR_W-1:0] SIG_BASE      = 10'd64,
    parameter int                SIG_DEPTH     = 8,
    localparam int               IDX_W         = (SIG_DEPTH > 1) ? $clog2(SIG_DEPTH) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    output logic                 core_rstn,
    input  logic [DATA_W-1:0]    idata,
    input  logic [ADDR_W-1:0]    iaddr,
    input  logic [ADDR_W-1:0]    daddr,
    input  logic [DATA_W-1:0]    ddata_w,
    input  logic                 d_w,
    input  logic [IDX_W-1:0]     sig_idx,
    output logic [DATA_W-1:0]    sig_data,
    output logic [SIG_DEPTH-1:0] sig_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [ADDR_W-1:0]    halt_pc,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     store_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [31:0]          phase_q, phase_d;
    logic [CNT_W-1:0]     cycle_q, cycle_d;
    logic [CNT_W-1:0]     store_q, store_d;
    logic                 timeout_q, timeout_d;
    logic [ADDR_W-1:0]    halt_pc_q, halt_pc_d;
    logic [SIG_DEPTH-1:0] valid_q, valid_d;
    logic                 busy_q, done_q, rstn_q;
    logic [DATA_W-1:0]    sig_mem_q [SIG_DEPTH];

    logic [31:0]          daddr_ext_s, off_s;
    logic                 in_win_s, monitor_s, cap_s, clr_s;
    logic [IDX_W-1:0]     widx_s;

    // Window test is done in 32 bits so SIG_BASE+SIG_DEPTH cannot wrap
    assign daddr_ext_s = 32'(daddr);
    assign off_s       = daddr_ext_s - 32'(SIG_BASE);
    assign in_win_s    = (daddr_ext_s >= 32'(SIG_BASE)) && (off_s < 32'(SIG_DEPTH));
    assign widx_s      = off_s[IDX_W-1:0];
    assign monitor_s   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign cap_s       = monitor_s && d_w && in_win_s;

    // Next-state, counters and run status
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cycle_d   = cycle_q;
        store_d   = store_q;
        timeout_d = timeout_q;
        halt_pc_d = halt_pc_q;
        clr_s     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RESET;
                    phase_d   = 32'd0;
                    cycle_d   = '0;
                    store_d   = '0;
                    timeout_d = 1'b0;
                    halt_pc_d = '0;
                    clr_s     = 1'b1;
                end else begin
                    state_d   = state_q;
                end
            end
            S_RESET: begin
                if (phase_q == 32'(RESET_CYCLES - 1)) begin
                    phase_d = 32'd0;
                    state_d = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            S_SETTLE: begin
                if (phase_q == 32'(SETTLE_CYCLES - 1)) begin
                    phase_d = 32'd0;
                    state_d = S_RUN;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            S_RUN: begin
                cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // Halt wins over a timeout landing in the same cycle
                if (idata == HALT_WORD) begin
                    halt_pc_d = iaddr;
                    phase_d   = 32'd0;
                    state_d   = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else if (cycle_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_RUN;
                end
            end
            S_DRAIN: begin
                cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (phase_q == 32'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (monitor_s && d_w && (store_q != '1)) begin
            store_d = store_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            store_d = store_d;
        end
    end

    // Per-word written flags; cleared at run start, set by in-window stores
    always_comb begin
        valid_d = valid_q;
        if (clr_s) begin
            valid_d = '0;
        end else if (cap_s) begin
            valid_d[widx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Control and status registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            phase_q   <= 32'd0;
            cycle_q   <= '0;
            store_q   <= '0;
            timeout_q <= 1'b0;
            halt_pc_q <= '0;
            valid_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rstn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cycle_q   <= cycle_d;
            store_q   <= store_d;
            timeout_q <= timeout_d;
            halt_pc_q <= halt_pc_d;
            valid_q   <= valid_d;
            busy_q    <= (state_d == S_RESET) || (state_d == S_SETTLE) ||
                         (state_d == S_RUN)   || (state_d == S_DRAIN);
            done_q    <= (state_d == S_DONE);
            rstn_q    <= (state_d != S_IDLE) && (state_d != S_RESET);
        end
    end

    // Signature storage keeps its contents across runs; sig_valid qualifies it
    always_ff @(posedge CLK) begin
        if (cap_s) begin
            sig_mem_q[widx_s] <= ddata_w;
        end
    end

    assign sig_data    = (32'(sig_idx) < 32'(SIG_DEPTH)) ? sig_mem_q[sig_idx] : '0;
    assign sig_valid   = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign halt_pc     = halt_pc_q;
    assign cycle_count = cycle_q;
    assign store_count = store_q;
    assign core_rstn   = rstn_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
`timescale 1ns/1ps
// Bench for cpu_run_monitor: a scripted fake core drives the buses, and a
// program-level model predicts halt/timeout, counts and the signature.
module tb_cpu_run_monitor;

    localparam int         TO = 100;
    localparam int         DR = 4;
    localparam int         SD = 8;
    localparam logic [9:0] SB = 10'd64;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        core_rstn;
    logic [31:0] idata = 32'h1;
    logic [9:0]  iaddr = 10'd0;
    logic [9:0]  daddr = 10'd0;
    logic [31:0] ddata_w = 32'd0;
    logic        d_w = 1'b0;
    logic [2:0]  sig_idx = 3'd0;
    logic [31:0] sig_data;
    logic [7:0]  sig_valid;
    logic        busy, done, timeout;
    logic [9:0]  halt_pc;
    logic [15:0] cycle_count, store_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_idata[$];
    logic [9:0]  q_iaddr[$];
    logic [9:0]  q_daddr[$];
    logic [31:0] q_ddata[$];
    bit          q_dw[$];
    bit          q_st[$];

    cpu_run_monitor #(
        .ADDR_W(10), .DATA_W(32), .HALT_WORD(32'h0000_0000),
        .RESET_CYCLES(3), .SETTLE_CYCLES(2), .DRAIN_CYCLES(DR),
        .TIMEOUT(TO), .CNT_W(16), .SIG_BASE(SB), .SIG_DEPTH(SD)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .core_rstn(core_rstn),
        .idata(idata), .iaddr(iaddr), .daddr(daddr), .ddata_w(ddata_w),
        .d_w(d_w), .sig_idx(sig_idx), .sig_data(sig_data),
        .sig_valid(sig_valid), .busy(busy), .done(done), .timeout(timeout),
        .halt_pc(halt_pc), .cycle_count(cycle_count), .store_count(store_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rstn"},  64'(core_rstn),   64'd0);
        chk({tag, "_busy"},  64'(busy),        64'd0);
        chk({tag, "_done"},  64'(done),        64'd0);
        chk({tag, "_tmo"},   64'(timeout),     64'd0);
        chk({tag, "_pc"},    64'(halt_pc),     64'd0);
        chk({tag, "_cyc"},   64'(cycle_count), 64'd0);
        chk({tag, "_st"},    64'(store_count), 64'd0);
        chk({tag, "_valid"}, 64'(sig_valid),   64'd0);
    endtask

    function automatic logic [31:0] nh();
        return $urandom | 32'h1;
    endfunction

    task automatic push(input logic [31:0] id, input logic [9:0] ia, input bit dw,
                        input logic [9:0] da, input logic [31:0] dd, input bit st);
        q_idata.push_back(id); q_iaddr.push_back(ia); q_dw.push_back(dw);
        q_daddr.push_back(da); q_ddata.push_back(dd); q_st.push_back(st);
    endtask

    task automatic clear_prog();
        q_idata.delete(); q_iaddr.delete(); q_dw.delete();
        q_daddr.delete(); q_ddata.delete(); q_st.delete();
    endtask

    // Straight-line program of n fetches, halt word at cycle h (h<0: none)
    task automatic gen_base(input int n, input int h);
        clear_prog();
        for (int i = 0; i < n; i++)
            push((i == h) ? 32'h0 : nh(), 10'(i * 4), 1'b0, 10'd0, 32'd0, 1'b0);
    endtask

    task automatic gen_rand(input int n, input int h);
        gen_base(n, h);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                q_dw[i]    = 1'b1;
                q_daddr[i] = 10'(int'(SB) - 3 + int'($urandom_range(0, SD + 6)));
                q_ddata[i] = $urandom;
            end
        end
    endtask

    task automatic put_store(input int i, input int off, input logic [31:0] v);
        q_dw[i] = 1'b1; q_daddr[i] = 10'(int'(SB) + off); q_ddata[i] = v;
    endtask

    // One complete run: model prediction, then start, reset/settle, program, checks
    task automatic run_prog(input int abort_at, input bit noisy);
        int n, h, last, e_cyc, e_st, idx;
        bit e_to;
        logic [9:0]  e_pc;
        logic [31:0] e_sig [SD];
        logic [7:0]  e_val;
        n = q_idata.size(); h = -1; e_st = 0; e_val = 8'd0;
        for (int i = 0; i < n && i < TO; i++)
            if (h < 0 && q_idata[i] == 32'h0) h = i;
        if (h >= 0) begin last = h + DR; e_to = 1'b0; e_pc = q_iaddr[h]; end
        else begin last = TO - 1; e_to = 1'b1; e_pc = 10'd0; end
        e_cyc = last + 1;
        for (int i = 0; i <= last; i++) begin
            if (q_dw[i]) begin
                e_st++;
                idx = int'(q_daddr[i]) - int'(SB);
                if (idx >= 0 && idx < SD) begin e_sig[idx] = q_ddata[i]; e_val[idx] = 1'b1; end
            end
        end

        @(negedge CLK); start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            start = 1'b0;
            chk("rstn_seq", 64'(core_rstn), (k >= 4) ? 64'd1 : 64'd0);
            chk("busy_seq", 64'(busy), 64'd1);
            chk("done_seq", 64'(done), 64'd0);
            d_w = noisy; daddr = 10'(int'(SB) + k); ddata_w = $urandom; idata = nh();
        end
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            chk("done_run", 64'(done), (i > last) ? 64'd1 : 64'd0);
            chk("busy_run", 64'(busy), (i > last) ? 64'd0 : 64'd1);
            chk("rstn_run", 64'(core_rstn), 64'd1);
            if (i == abort_at) begin
                RST = 1'b1;
                #1;
                chk_reset_state("abort");
                #1;
                RST = 1'b0; d_w = 1'b0; start = 1'b0; idata = 32'h1;
                return;
            end
            idata = q_idata[i]; iaddr = q_iaddr[i]; d_w = q_dw[i];
            daddr = q_daddr[i]; ddata_w = q_ddata[i]; start = q_st[i];
        end
        @(negedge CLK);
        d_w = 1'b0; start = 1'b0; idata = 32'h1;
        chk("done",  64'(done),        64'd1);
        chk("busy",  64'(busy),        64'd0);
        chk("tmo",   64'(timeout),     64'(e_to));
        chk("pc",    64'(halt_pc),     64'(e_pc));
        chk("cyc",   64'(cycle_count), 64'(e_cyc));
        chk("st",    64'(store_count), 64'(e_st));
        chk("valid", 64'(sig_valid),   64'(e_val));
        for (int j = 0; j < SD; j++) begin
            if (e_val[j]) begin
                @(negedge CLK); sig_idx = 3'(j); #1;
                chk("sig", 64'(sig_data), 64'(e_sig[j]));
            end
        end
    endtask

    initial begin
        int a, b, t, h;
        // Held reset, then idle without start
        repeat (2) @(negedge CLK);
        chk_reset_state("rst");
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_state("idle");

        // Fibonacci stores to words 0..7, halt fetched at iaddr 40
        clear_prog(); a = 0; b = 1;
        for (int i = 0; i < 20; i++) begin
            push((i == 10) ? 32'h0 : nh(), 10'(i * 4), (i < 8) || (i >= 15),
                 (i < 8) ? 10'(int'(SB) + i) : SB, (i < 8) ? 32'(a) : nh(), 1'b0);
            if (i < 8) begin t = a + b; a = b; b = t; end
        end
        run_prog(-1, 1'b1);
        chk("fib_pc", 64'(halt_pc), 64'd40);
        chk("fib_valid", 64'(sig_valid), 64'hFF);
        chk("fib_tmo", 64'(timeout), 64'd0);

        // Drain boundary: h+3 and final drain cycle h+4 captured, h+5 not
        gen_base(16, 5);
        put_store(8, 2, 32'hA5A5_0003); put_store(9, 3, 32'hA5A5_0004); put_store(10, 4, 32'hA5A5_0005);
        run_prog(-1, 1'b0);
        gen_base(16, 5);
        put_store(10, 2, 32'hDEAD_0005);
        run_prog(-1, 1'b0);
        chk("late_valid2", 64'(sig_valid[2]), 64'd0);

        // Infinite loop with a start pulse mid-run: timeout at cycle TO
        gen_rand(110, -1);
        q_st[50] = 1'b1;
        run_prog(-1, 1'b1);
        chk("to_cyc", 64'(cycle_count), 64'(TO));
        chk("to_flag", 64'(timeout), 64'd1);

        // Halt fetched in the timeout cycle: halt wins, drain follows
        gen_rand(110, TO - 1);
        run_prog(-1, 1'b0);

        // Asynchronous abort mid-run, then the same program run to completion
        gen_rand(60, 30);
        run_prog(12, 1'b0);
        repeat (2) @(negedge CLK);
        chk_reset_state("post_abort");
        run_prog(-1, 1'b0);

        // Random programs, some halting, some timing out
        for (int r = 0; r < 6; r++) begin
            h = int'($urandom_range(0, 140));
            if (h >= TO) h = -1;
            gen_rand(115, h);
            q_st[1] = 1'b1;
            run_prog(-1, bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
